inst_fetch_unit: RTL
====================

Name: inst_fetch_unit

Overview:
- Program-counter and instruction-memory stage directly upstream of the CGRA instruction decoder.
- Holds the kernel program in a local instruction memory loaded by the host. Sequences the PC, resolves bne redirects from the scalar datapath, stalls while vector work is in flight, and parks on WFI until the steady-state done condition is reached.
- Presents one registered instruction per cycle to the decoder.

Parameters:
- dwidth_inst, 32, instruction width in bits.
- IMEM_DEPTH, 256, instruction words in memory (power of two).
- IMEM_AW, $clog2(IMEM_DEPTH), word-address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- ap_start  in  1  start request, level-sensitive, sampled in IDLE/HALT
- imem_wen  in  1  host program-load write enable
- imem_waddr  in  IMEM_AW  host word address
- imem_wdata  in  dwidth_inst  host instruction word
- stall  in  1  hold fetch (vector op in flight / downstream not ready)
- branch_taken  in  1  scalar compare result for the presented bne
- branch_immediate  in  12  decoded B-type imm[12:1]
- done_steady  in  1  pipeline drained, consumed with WFI
- instr  out  dwidth_inst  instruction presented to decoder
- instr_valid  out  1  instr is meaningful this cycle
- pc  out  IMEM_AW+2  byte address of presented instr
- ap_idle  out  1  high in IDLE or HALT
- halted  out  1  high in HALT only

Behaviour:
- Reset (async, any state): state=IDLE, pc=0, instr=0, instr_valid=0, ap_idle=1, halted=0. Memory contents are not cleared.
- Instruction memory: synchronous read, single-port write.
  - Read address is next_pc[IMEM_AW+1:2]; instr is registered, so the fetch for the presented PC happened one cycle earlier.
  - Addresses wrap modulo IMEM_DEPTH.
- Host writes:
  - Accepted only in IDLE or HALT; dropped silently in RUN/WAIT_DONE.
  - Write then start in consecutive cycles is legal. Write-before-read applies to the same address in the same cycle.
- States:
  - IDLE: instr_valid=0. On ap_start go to RUN: next_pc=0, so the cycle after entering RUN presents mem[0] with instr_valid=1.
  - RUN: per cycle, next_pc is chosen by the first matching rule:
    - stall=1: next_pc=pc; instr and pc held; instr_valid stays 1.
    - Presented instr is bne (opcode 1100011, funct3 001) and branch_taken=1: next_pc=pc+sext({branch_immediate,1'b0}), truncated to IMEM_AW+2 bits. Zero bubbles.
    - Presented instr is WFI (32'h10500073): next_pc=pc; go to WAIT_DONE.
    - Otherwise: next_pc=pc+4.
  - WAIT_DONE: WFI held with instr_valid=1 so the decoder can assert ap_done. When done_steady=1, go to HALT next cycle.
  - HALT: instr_valid=0, halted=1, ap_idle=1. ap_start re-runs from pc=0.
- Precedence:
  - stall beats branch and WFI. branch_taken is ignored while stall=1; the upstream ALU must re-present it when the stall releases.
  - branch_taken on a non-bne instruction is ignored.
  - done_steady while in RUN is ignored; only WFI arms it.
- Bits [1:0] of pc are always 0. A misaligned branch target has bit 1 forced to 0.
- ap_start while RUN/WAIT_DONE is ignored.

Test Plan:
- Load {addi, addi, WFI} at words 0-2, pulse ap_start, done_steady=1 on WFI -> pc sequence 0,4,8 with instr_valid=1; WFI held 1 cycle; then HALT, halted=1, instr_valid=0.
- bne at word 5, branch_immediate=12'hFFC (-8 bytes), branch_taken=1 -> next presented pc=0x0C (word 3), no bubble. Same with branch_taken=0 -> pc=0x18.
- stall held 3 cycles on a bne with branch_taken=1 -> pc and instr frozen 3 cycles; branch ignored; after release with branch_taken=0 -> pc+4.
- WFI presented, done_steady low for 5 cycles then high -> instr stays WFI with instr_valid=1 for 5 cycles, HALT the cycle after done_steady.
- Host write to word 0 during RUN -> memory unchanged; rerun after HALT fetches original word.
- Assert rst mid-RUN at pc=0x20 -> immediately instr_valid=0, pc=0, ap_idle=1. ap_start after release fetches from word 0.

Source files
------------

// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit: PC sequencing and instruction memory in front of the CGRA decoder
module inst_fetch_unit #(
  parameter int dwidth_inst = 32,
  parameter int IMEM_DEPTH  = 256,
  parameter int IMEM_AW     = $clog2(IMEM_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ap_start,
  input  logic                   imem_wen,
  input  logic [IMEM_AW-1:0]     imem_waddr,
  input  logic [dwidth_inst-1:0] imem_wdata,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [11:0]            branch_immediate,
  input  logic                   done_steady,
  output logic [dwidth_inst-1:0] instr,
  output logic                   instr_valid,
  output logic [IMEM_AW+1:0]     pc,
  output logic                   ap_idle,
  output logic                   halted
);
  localparam int PW = IMEM_AW + 2;
  typedef enum logic [1:0] {IDLE, RUN, WAIT_DONE, HALT} state_t;
  state_t state, state_nxt;
  logic [dwidth_inst-1:0] mem [IMEM_DEPTH];
  logic [PW-1:0] pc_nxt, br_target;
  logic [IMEM_AW-1:0] raddr;
  logic is_bne, is_wfi, host_ok, load, wr_en;
  assign is_bne    = instr[6:0] == 7'b1100011 && instr[14:12] == 3'b001;
  assign is_wfi    = instr == dwidth_inst'(32'h10500073);
  assign host_ok   = state == IDLE || state == HALT;
  assign wr_en     = imem_wen && host_ok;
  // offset is sign-extended then truncated to the PC width; bit 1 is forced low for misaligned targets
  assign br_target = (pc + PW'($signed({branch_immediate, 1'b0}))) & ~PW'(3);
  assign pc_nxt    = host_ok ? '0 :
                     (state == RUN && !stall) ? ((is_bne && branch_taken) ? br_target :
                                                 is_wfi ? pc : pc + PW'(4)) : pc;
  assign raddr     = pc_nxt[PW-1:2];
  // idle/halted states only refetch when a run is launched
  assign load      = host_ok ? ap_start : 1'b1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      pc    <= '0;
      instr <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        pc    <= pc_nxt;
        instr <= (wr_en && imem_waddr == raddr) ? imem_wdata : mem[raddr];
      end
    end
  end
  always_ff @(posedge clk)
    if (wr_en) mem[imem_waddr] <= imem_wdata;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, HALT: state_nxt = ap_start ? RUN : state;
      RUN:        state_nxt = (!stall && is_wfi) ? WAIT_DONE : RUN;
      WAIT_DONE:  state_nxt = done_steady ? HALT : WAIT_DONE;
      default:    state_nxt = IDLE;
    endcase
  end
  always_comb begin
    instr_valid = state == RUN || state == WAIT_DONE;
    ap_idle     = host_ok;
    halted      = state == HALT;
  end
endmodule
